imem_load_ctrl: RTL and testbench
=================================

Name: imem_load_ctrl

Overview:
Controller that owns the single-port-enable instruction memory (32 x WIDTH, negedge-clocked, en/write_valid gated).
- Sequences a zero-clear sweep after reset.
- Accepts a host program-load stream (valid/ready), then serves CPU fetch requests with one-cycle latency.
- Keeps the CPU stalled whenever the memory is owned by clear or load traffic. Sits between the boot/host interface, the fetch stage and the instruction memory.

Parameters:
WIDTH, 32, instruction word width
ADDR_BITS, 32, width of all address ports
DEPTH, 32, number of memory words; valid addresses 0..DEPTH-1

Ports:
clk  in  1  system clock; controller logic is posedge
reset  in  1  synchronous, active-high reset
host_start  in  1  request a program load; sampled in IDLE and RUN
host_base  in  ADDR_BITS  first load address, captured on accepted host_start
host_valid  in  1  host word valid
host_data  in  WIDTH  host word
host_last  in  1  marks final word of the load
host_ready  out  1  controller accepts host word this cycle
fetch_req  in  1  CPU fetch request
fetch_adr  in  ADDR_BITS  fetch word address
fetch_ready  out  1  fetch accepted this cycle when fetch_req=1
fetch_valid  out  1  fetch_instr valid (registered)
fetch_instr  out  WIDTH  fetched instruction (registered)
cpu_stall  out  1  high whenever state is not RUN
load_count  out  ADDR_BITS  words written by the current/last load
load_err  out  1  sticky: a load address reached >= DEPTH
mem_en  out  1  to memory en
mem_write_valid  out  1  to memory write_valid
mem_read_adr  out  ADDR_BITS  to memory read_adr
mem_write_adr  out  ADDR_BITS  to memory write_adr
mem_instr_in  out  WIDTH  to memory instr_in
mem_instr_out  in  WIDTH  from memory instr_out

Behaviour:
- Reset: synchronous, active-high; applies in any state.
  - Next state is CLEAR; clr_ptr=0.
  - Outputs during and after reset: host_ready=0, fetch_ready=0, fetch_valid=0, fetch_instr=0, load_count=0, load_err=0, cpu_stall=1.
  - A reset mid-load or mid-fetch drops that transaction; no fetch_valid follows.
- Memory-side outputs are combinational from state and inputs, so they are stable before the memory's negedge.
  - Idle defaults: mem_en=0, mem_write_valid=0, addresses 0, data 0.
- CLEAR: mem_en=1, mem_write_valid=1, mem_write_adr=clr_ptr, mem_instr_in=0; clr_ptr increments each cycle.
  - Lasts exactly DEPTH cycles, then goes to IDLE.
- IDLE: cpu_stall=1.
  - host_start: capture host_base into wr_ptr, clear load_count and load_err, go to LOAD.
- LOAD: host_ready=1.
  - Handshake: a word is accepted when host_valid && host_ready. On acceptance: mem_en=1, mem_write_valid=1, mem_write_adr=wr_ptr, mem_instr_in=host_data; wr_ptr+1, load_count+1.
  - Range check: if wr_ptr >= DEPTH, the write is suppressed (mem_write_valid=0) and load_err is set sticky. The word is still counted and accepted, so the host never hangs.
  - An accepted word with host_last=1 moves the state to RUN next cycle. Only host_last with host_valid is meaningful.
- RUN: cpu_stall=0, fetch_ready=1.
  - Fetch accepted in cycle N: mem_en=1, mem_read_adr=fetch_adr.
  - At the posedge ending cycle N: fetch_instr<=mem_instr_out and fetch_valid<=1. Latency 1; throughput 1 per cycle.
  - A cycle with no accepted fetch clears fetch_valid; fetch_instr holds its value.
  - fetch_adr >= DEPTH: accepted; fetch_instr<=0, fetch_valid<=1; mem_en=0.
- RUN with host_start: has priority over fetch_req in the same cycle.
  - fetch_ready=0 that cycle; go to LOAD with the same captures as from IDLE.
  - A fetch accepted in the previous cycle still produces its fetch_valid.
- fetch_req and fetch_ready are never both required in LOAD, CLEAR or IDLE; fetch_req is ignored there.
- Width rules: pointers are ADDR_BITS wide and compare unsigned against DEPTH. load_count saturates at all-ones.

Decomposition:
- Shared package: state encoding (CLEAR, IDLE, LOAD, RUN as 2-bit localparams) and the DEPTH default.
- No sub-module is needed; the controller and the instr_mem instance are wired together at the level above.
- A thin wrapper tile, imem_subsys, instantiating imem_load_ctrl plus instr_mem is natural for integration tests.

Test Plan:
- Reset clear: pulse reset for 1 cycle -> exactly 32 cycles with mem_write_valid=1, addresses 0..31, data 0; then IDLE with cpu_stall=1.
- Basic load: host_start with host_base=4; 3 words 0xA, 0xB, 0xC with host_last on the third -> writes to addresses 4, 5, 6; load_count=3; RUN; cpu_stall=0.
- Back-to-back fetch: fetch addresses 4, 5, 6 on consecutive cycles -> fetch_valid high for 3 cycles one cycle later, with fetch_instr 0xA, 0xB, 0xC; address 0 returns 0.
- Overflow load: host_base=30, 4 words -> addresses 30 and 31 written; the last two suppressed; load_err=1; load_count=4; host never stalled.
- Reload mid-run: fetch_req and host_start in the same RUN cycle -> fetch_ready=0, state LOAD, cpu_stall=1. The previous cycle's fetch still returns fetch_valid.
- Reset mid-load: assert reset after 2 of 5 words -> state CLEAR, host_ready=0, load_count=0, no further writes except the clear sweep.

Source files
------------

// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory load controller:
// controller state encoding and the default memory depth.
package imem_load_ctrl_pkg;

  localparam int DEPTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

endpackage

// File: rtl/imem_load_ctrl.sv
// Owner of the instruction memory: zero-clear sweep after reset, host program
// load (valid/ready), then one-cycle-latency CPU fetches while the CPU runs.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 32,
  parameter int DEPTH     = DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_start,
  input  logic [ADDR_BITS-1:0] host_base,
  input  logic                 host_valid,
  input  logic [WIDTH-1:0]     host_data,
  input  logic                 host_last,
  output logic                 host_ready,
  input  logic                 fetch_req,
  input  logic [ADDR_BITS-1:0] fetch_adr,
  output logic                 fetch_ready,
  output logic                 fetch_valid,
  output logic [WIDTH-1:0]     fetch_instr,
  output logic                 cpu_stall,
  output logic [ADDR_BITS-1:0] load_count,
  output logic                 load_err,
  output logic                 mem_en,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_read_adr,
  output logic [ADDR_BITS-1:0] mem_write_adr,
  output logic [WIDTH-1:0]     mem_instr_in,
  input  logic [WIDTH-1:0]     mem_instr_out
);

  localparam logic [ADDR_BITS-1:0] DEPTH_A = ADDR_BITS'(DEPTH);
  localparam logic [ADDR_BITS-1:0] ONE_A   = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] ALL1_A  = {ADDR_BITS{1'b1}};

  state_e               state_r;
  state_e               state_next_s;
  logic [ADDR_BITS-1:0] clr_ptr_r;
  logic [ADDR_BITS-1:0] wr_ptr_r;
  logic [ADDR_BITS-1:0] load_count_r;
  logic                 load_err_r;
  logic                 fetch_valid_r;
  logic [WIDTH-1:0]     fetch_instr_r;

  logic start_s;
  logic host_acc_s;
  logic fetch_acc_s;
  logic wr_in_range_s;
  logic fetch_in_range_s;

  assign wr_in_range_s    = (wr_ptr_r < DEPTH_A);
  assign fetch_in_range_s = (fetch_adr < DEPTH_A);

  assign fetch_valid = fetch_valid_r;
  assign fetch_instr = fetch_instr_r;
  assign load_count  = load_count_r;
  assign load_err    = load_err_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state, handshakes and memory drive; everything is forced idle while
  // reset is high so nothing reaches the memory during a reset cycle.
  always_comb begin
    state_next_s    = state_r;
    start_s         = 1'b0;
    host_acc_s      = 1'b0;
    fetch_acc_s     = 1'b0;
    host_ready      = 1'b0;
    fetch_ready     = 1'b0;
    cpu_stall       = 1'b1;
    mem_en          = 1'b0;
    mem_write_valid = 1'b0;
    mem_read_adr    = '0;
    mem_write_adr   = '0;
    mem_instr_in    = '0;
    if (reset) begin
      state_next_s = ST_CLEAR;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          mem_en          = 1'b1;
          mem_write_valid = 1'b1;
          mem_write_adr   = clr_ptr_r;
          if (clr_ptr_r == DEPTH_A - ONE_A) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_CLEAR;
          end
        end
        ST_IDLE: begin
          if (host_start) begin
            start_s      = 1'b1;
            state_next_s = ST_LOAD;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          host_ready = 1'b1;
          if (host_valid) begin
            // Out-of-range words are still accepted so the host never hangs.
            host_acc_s      = 1'b1;
            mem_en          = 1'b1;
            mem_write_valid = wr_in_range_s;
            mem_write_adr   = wr_ptr_r;
            mem_instr_in    = host_data;
            state_next_s    = host_last ? ST_RUN : ST_LOAD;
          end else begin
            state_next_s = ST_LOAD;
          end
        end
        ST_RUN: begin
          cpu_stall = 1'b0;
          if (host_start) begin
            start_s      = 1'b1;
            state_next_s = ST_LOAD;
          end else begin
            fetch_ready  = 1'b1;
            state_next_s = ST_RUN;
            if (fetch_req) begin
              fetch_acc_s  = 1'b1;
              mem_en       = fetch_in_range_s;
              mem_read_adr = fetch_in_range_s ? fetch_adr : '0;
            end else begin
              fetch_acc_s = 1'b0;
            end
          end
        end
        default: begin
          state_next_s = ST_CLEAR;
        end
      endcase
    end
  end

  // Clear pointer, load pointer/counters and the registered fetch response.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_ptr_r     <= '0;
      wr_ptr_r      <= '0;
      load_count_r  <= '0;
      load_err_r    <= 1'b0;
      fetch_valid_r <= 1'b0;
      fetch_instr_r <= '0;
    end else begin
      clr_ptr_r <= (state_r == ST_CLEAR) ? clr_ptr_r + ONE_A : '0;
      if (start_s) begin
        wr_ptr_r     <= host_base;
        load_count_r <= '0;
        load_err_r   <= 1'b0;
      end else if (host_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_A;
        if (load_count_r != ALL1_A) begin
          load_count_r <= load_count_r + ONE_A;
        end
        if (!wr_in_range_s) begin
          load_err_r <= 1'b1;
        end
      end
      fetch_valid_r <= fetch_acc_s;
      if (fetch_acc_s) begin
        fetch_instr_r <= fetch_in_range_s ? mem_instr_out : '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: behavioural model with a per-cycle
// comparator, a negedge memory, and directed vectors with literal expectations.
module tb_imem_load_ctrl;

  localparam int W  = 32;
  localparam int AB = 32;
  localparam int D  = 32;
  localparam int P_CLR  = 0;
  localparam int P_IDLE = 1;
  localparam int P_LOAD = 2;
  localparam int P_RUN  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_start;
  logic [AB-1:0] host_base;
  logic          host_valid;
  logic [W-1:0]  host_data;
  logic          host_last;
  logic          host_ready;
  logic          fetch_req;
  logic [AB-1:0] fetch_adr;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [W-1:0]  fetch_instr;
  logic          cpu_stall;
  logic [AB-1:0] load_count;
  logic          load_err;
  logic          mem_en;
  logic          mem_write_valid;
  logic [AB-1:0] mem_read_adr;
  logic [AB-1:0] mem_write_adr;
  logic [W-1:0]  mem_instr_in;
  logic [W-1:0]  mem_instr_out;

  imem_load_ctrl #(.WIDTH(W), .ADDR_BITS(AB), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .host_start(host_start), .host_base(host_base), .host_valid(host_valid),
    .host_data(host_data), .host_last(host_last), .host_ready(host_ready),
    .fetch_req(fetch_req), .fetch_adr(fetch_adr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .cpu_stall(cpu_stall),
    .load_count(load_count), .load_err(load_err),
    .mem_en(mem_en), .mem_write_valid(mem_write_valid),
    .mem_read_adr(mem_read_adr), .mem_write_adr(mem_write_adr),
    .mem_instr_in(mem_instr_in), .mem_instr_out(mem_instr_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction memory stand-in: negedge-clocked, write wins over read.
  logic [W-1:0] bmem [D];
  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_write_valid) begin
        if (mem_write_adr < D) bmem[mem_write_adr[4:0]] <= mem_instr_in;
      end else begin
        mem_instr_out <= bmem[mem_read_adr[4:0]];
      end
    end
  end

  // Behavioural model: phase, what the memory must hold, expected outputs.
  bit            model_ok;
  int            phase;
  int            clr_left;
  logic [31:0]   m_wr;
  logic [31:0]   m_cnt;
  logic          m_err;
  logic          m_fv;
  logic [W-1:0]  m_fi;
  logic [W-1:0]  mmem [D];

  always @(posedge clk) begin
    if (reset) begin
      model_ok <= 1'b1;
      phase    <= P_CLR;
      clr_left <= D;
      m_wr     <= 32'd0;
      m_cnt    <= 32'd0;
      m_err    <= 1'b0;
      m_fv     <= 1'b0;
      m_fi     <= '0;
    end else if (model_ok) begin
      m_fv <= 1'b0;
      case (phase)
        P_CLR: begin
          mmem[D - clr_left] <= '0;
          clr_left <= clr_left - 1;
          if (clr_left == 1) phase <= P_IDLE;
        end
        P_IDLE: if (host_start) begin
          phase <= P_LOAD; m_wr <= host_base; m_cnt <= 32'd0; m_err <= 1'b0;
        end
        P_LOAD: if (host_valid) begin
          if (m_wr < D) mmem[m_wr[4:0]] <= host_data;
          else m_err <= 1'b1;
          m_wr <= m_wr + 32'd1;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
          if (host_last) phase <= P_RUN;
        end
        P_RUN: begin
          if (host_start) begin
            phase <= P_LOAD; m_wr <= host_base; m_cnt <= 32'd0; m_err <= 1'b0;
          end else if (fetch_req) begin
            m_fv <= 1'b1;
            m_fi <= (fetch_adr < D) ? mmem[fetch_adr[4:0]] : '0;
          end
        end
        default: ;
      endcase
    end
  end

  logic        exp_hr, exp_fr, exp_stall, exp_en, exp_wv;
  logic [31:0] exp_wa, exp_ra, exp_wd;
  always_comb begin
    exp_hr = 1'b0; exp_fr = 1'b0; exp_stall = 1'b1; exp_en = 1'b0; exp_wv = 1'b0;
    exp_wa = 32'd0; exp_ra = 32'd0; exp_wd = 32'd0;
    if (!reset) begin
      case (phase)
        P_CLR: begin exp_en = 1'b1; exp_wv = 1'b1; exp_wa = 32'(D - clr_left); end
        P_LOAD: begin
          exp_hr = 1'b1; exp_en = host_valid; exp_wv = host_valid && (m_wr < D);
          exp_wa = m_wr; exp_wd = host_data;
        end
        P_RUN: begin
          exp_stall = 1'b0; exp_fr = !host_start;
          if (!host_start && fetch_req && fetch_adr < D) begin
            exp_en = 1'b1; exp_ra = fetch_adr;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparator, mid-cycle; also tallies memory writes.
  int wv_total = 0;
  always @(negedge clk) begin
    if (model_ok) begin
      chk("host_ready", {31'd0, host_ready}, {31'd0, exp_hr});
      chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, exp_fr});
      chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, exp_stall});
      chk("mem_en", {31'd0, mem_en}, {31'd0, exp_en});
      chk("mem_write_valid", {31'd0, mem_write_valid}, {31'd0, exp_wv});
      if (exp_wv) begin
        chk("mem_write_adr", mem_write_adr, exp_wa);
        chk("mem_instr_in", mem_instr_in, exp_wd);
      end
      if (exp_en && !exp_wv) chk("mem_read_adr", mem_read_adr, exp_ra);
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fv});
      chk("fetch_instr", fetch_instr, m_fi);
      chk("load_count", load_count, m_cnt);
      chk("load_err", {31'd0, load_err}, {31'd0, m_err});
    end
    wv_total <= wv_total + (mem_write_valid ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch1(input logic [31:0] adr, input logic [31:0] exp, input string nm);
    fetch_req = 1'b1; fetch_adr = adr;
    tick();
    chk({nm, "_valid"}, {31'd0, fetch_valid}, 32'd1);
    chk(nm, fetch_instr, exp);
  endtask

  task automatic word(input logic [31:0] data, input logic last);
    host_valid = 1'b1; host_data = data; host_last = last;
    #1;
    chk("host_never_stalled", {31'd0, host_ready}, 32'd1);
    tick();
    host_valid = 1'b0; host_last = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  int base;
  initial begin
    reset = 1'b1; host_start = 1'b0; host_base = '0; host_valid = 1'b0;
    host_data = '0; host_last = 1'b0; fetch_req = 1'b0; fetch_adr = '0;
    tick(); tick();
    chk("rst_stall", {31'd0, cpu_stall}, 32'd1);
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_load_count", load_count, 32'd0);
    reset = 1'b0;
    base = wv_total;
    repeat (34) tick();
    chk("clear_writes", 32'(wv_total - base), 32'd32);
    chk("idle_stall", {31'd0, cpu_stall}, 32'd1);

    // Basic load at base 4.
    host_start = 1'b1; host_base = 32'd4;
    tick();
    host_start = 1'b0;
    word(32'hA, 1'b0); word(32'hB, 1'b0); word(32'hC, 1'b1);
    chk("basic_load_count", load_count, 32'd3);
    chk("basic_run_stall", {31'd0, cpu_stall}, 32'd0);

    // Back-to-back fetches, out-of-range and cleared address.
    fetch1(32'd4, 32'hA, "fetch4");
    fetch1(32'd5, 32'hB, "fetch5");
    fetch1(32'd6, 32'hC, "fetch6");
    fetch1(32'd40, 32'h0, "fetch40");
    fetch1(32'd0, 32'h0, "fetch0");
    fetch1(32'd5, 32'hB, "fetch5b");
    fetch_req = 1'b0;
    tick();
    chk("idle_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("hold_fetch_instr", fetch_instr, 32'hB);

    // Reload mid-run: previous fetch still returns.
    fetch_req = 1'b1; fetch_adr = 32'd6;
    tick();
    host_start = 1'b1; host_base = 32'd30; fetch_adr = 32'd4;
    #1;
    chk("reload_fetch_ready", {31'd0, fetch_ready}, 32'd0);
    chk("reload_prev_valid", {31'd0, fetch_valid}, 32'd1);
    chk("reload_prev_instr", fetch_instr, 32'hC);
    tick();
    host_start = 1'b0; fetch_req = 1'b0;
    chk("reload_stall", {31'd0, cpu_stall}, 32'd1);
    chk("reload_no_valid", {31'd0, fetch_valid}, 32'd0);

    // Overflow load at base 30, four words.
    word(32'h100, 1'b0); word(32'h101, 1'b0); word(32'h102, 1'b0); word(32'h103, 1'b1);
    chk("ovf_err", {31'd0, load_err}, 32'd1);
    chk("ovf_count", load_count, 32'd4);
    fetch1(32'd30, 32'h100, "fetch30");
    fetch1(32'd31, 32'h101, "fetch31");
    fetch_req = 1'b0;
    tick();

    // Reset in the middle of a load.
    host_start = 1'b1; host_base = 32'd0;
    tick();
    host_start = 1'b0;
    word(32'h55, 1'b0); word(32'h66, 1'b0);
    chk("midload_count", load_count, 32'd2);
    host_valid = 1'b1; host_data = 32'h77; reset = 1'b1;
    #1;
    chk("rstload_host_ready", {31'd0, host_ready}, 32'd0);
    chk("rstload_no_write", {31'd0, mem_write_valid}, 32'd0);
    tick();
    reset = 1'b0; host_valid = 1'b0;
    base = wv_total;
    #1;
    chk("rstload_count", load_count, 32'd0);
    chk("rstload_err", {31'd0, load_err}, 32'd0);
    chk("rstload_stall", {31'd0, cpu_stall}, 32'd1);
    repeat (34) tick();
    chk("rstload_clear_writes", 32'(wv_total - base), 32'd32);

    host_start = 1'b1; host_base = 32'd10;
    tick();
    host_start = 1'b0;
    word(32'h99, 1'b1);
    chk("final_count", load_count, 32'd1);
    fetch1(32'd0, 32'h0, "fetch0_cleared");
    fetch1(32'd10, 32'h99, "fetch10");
    fetch_req = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
